// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state encoding and default sizing for the mux scan controller
// Purpose: FSM state type plus default channel count and dwell length.
// Ports: none (package).
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    localparam int DEF_SIZE  = 8;
    localparam int DEF_DWELL = 4;

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// rtl/mux_scan_dwell_cnt.sv - per-channel dwell counter for the mux scan controller
// Purpose: counts 0..DWELL-1 while enabled and wraps to 0 after the last cycle.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   clear  in  force count to 0 (takes priority over enable)
//   enable in  advance count by one
//   last   out high when count = DWELL-1
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    // A one-cycle dwell still needs a one-bit register; it simply never leaves 0.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            if (last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign last = (r_cnt == LAST_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sweeps an external N:1 mux and captures one bit per channel
// Purpose: on start, steps the mux select through channels 0..SIZE-1, holding each for
//          DWELL cycles and sampling the mux output at the end of each dwell; the full
//          word is published with a one-cycle done pulse.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   mux_scan_start in   request one sweep (honoured only in IDLE)
//   mux_scan_abort in   cancel an active sweep; blocks a simultaneous start in IDLE
//   mux_scan_sel   out  select to the external mux (0 outside SCAN)
//   mux_scan_in    in   bit returned by the external mux
//   mux_scan_data  out  captured word, bit k = channel k
//   mux_scan_busy  out  high while sweeping
//   mux_scan_done  out  one-cycle pulse when mux_scan_data has been updated
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SIZE  = DEF_SIZE,
    parameter int DWELL = DEF_DWELL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mux_scan_start,
    input  logic                    mux_scan_abort,
    output logic [$clog2(SIZE)-1:0] mux_scan_sel,
    input  logic                    mux_scan_in,
    output logic [SIZE-1:0]         mux_scan_data,
    output logic                    mux_scan_busy,
    output logic                    mux_scan_done
);

    localparam int SW = $clog2(SIZE);
    localparam logic [SW-1:0] LAST_IDX = SW'(SIZE - 1);

    scan_state_t     r_state;
    scan_state_t     w_state_next;
    logic [SW-1:0]   r_idx;
    logic [SIZE-1:0] r_shadow;
    logic [SIZE-1:0] r_data;
    logic [SIZE-1:0] w_shadow_next;
    logic            w_last;
    logic            w_start_ok;
    logic            w_sample;
    logic            w_final;

    // Counter is held at 0 outside SCAN so every sweep starts with a full dwell.
    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (r_state != ST_SCAN),
        .enable (r_state == ST_SCAN),
        .last   (w_last)
    );

    assign w_start_ok = (r_state == ST_IDLE) && mux_scan_start && !mux_scan_abort;
    // Abort takes priority over the sample edge, including the final one.
    assign w_sample   = (r_state == ST_SCAN) && !mux_scan_abort && w_last;
    assign w_final    = w_sample && (r_idx == LAST_IDX);

    // Shadow word with the current channel's bit replaced by the mux return value;
    // loading this into mux_scan_data keeps the final sample in the published word.
    always_comb begin
        w_shadow_next = r_shadow;
        for (int k = 0; k < SIZE; k++) begin
            if (r_idx == SW'(k)) begin
                w_shadow_next[k] = mux_scan_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        mux_scan_sel  = '0;
        mux_scan_busy = 1'b0;
        mux_scan_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                mux_scan_sel  = r_idx;
                mux_scan_busy = 1'b1;
                if (mux_scan_abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_final) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                mux_scan_done = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_shadow <= '0;
            r_data   <= '0;
        end else if (w_start_ok) begin
            r_idx    <= '0;
            r_shadow <= '0;
        end else if (w_sample) begin
            r_shadow <= w_shadow_next;
            if (w_final) begin
                r_data <= w_shadow_next;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign mux_scan_data = r_data;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

    localparam int SZ  = 8;
    localparam int DW  = 4;
    localparam int SZ5 = 5;
    localparam int DW5 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;

    logic       start8, abort8, in8, busy8, done8;
    logic [2:0] sel8;
    logic [7:0] data8, word8;

    logic       start5, abort5, in5, busy5, done5;
    logic [2:0] sel5;
    logic [4:0] data5, word5;

    // External 8:1 and 5:1 muxes closing the loop around each DUT.
    assign in8 = word8[sel8];
    assign in5 = (sel5 < 3'd5) ? word5[sel5] : 1'b0;

    mux_scan_ctrl #(.SIZE(SZ), .DWELL(DW)) u_dut8 (
        .clk            (clk),
        .rst_n          (rst_n),
        .mux_scan_start (start8),
        .mux_scan_abort (abort8),
        .mux_scan_sel   (sel8),
        .mux_scan_in    (in8),
        .mux_scan_data  (data8),
        .mux_scan_busy  (busy8),
        .mux_scan_done  (done8)
    );

    mux_scan_ctrl #(.SIZE(SZ5), .DWELL(DW5)) u_dut5 (
        .clk            (clk),
        .rst_n          (rst_n),
        .mux_scan_start (start5),
        .mux_scan_abort (abort5),
        .mux_scan_sel   (sel5),
        .mux_scan_in    (in5),
        .mux_scan_data  (data5),
        .mux_scan_busy  (busy5),
        .mux_scan_done  (done5)
    );

    typedef struct {
        logic [7:0] word_a;
        logic [7:0] word_b;
        int         switch_cycle;
        int         abort_cycle;
        int         restart_cycle;
        logic [7:0] exp_data;
        logic       exp_done;
    } sweep_vec_t;

    sweep_vec_t vecs [7];

    int         total = 0;
    int         bad   = 0;
    logic [7:0] q8 [$];
    logic [4:0] q5 [$];
    logic [7:0] last8;
    logic [7:0] exp8_v;
    logic [4:0] exp5_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboards: each done pulse consumes one expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb8_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                exp8_v = q8.pop_front();
                check("sb8_data", {24'd0, data8}, {24'd0, exp8_v});
            end
        end
        if (rst_n === 1'b1 && done5 === 1'b1) begin
            if (q5.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb5_unexpected_done: got done=1 expected no pending sweep");
            end else begin
                exp5_v = q5.pop_front();
                check("sb5_data", {27'd0, data5}, {27'd0, exp5_v});
            end
        end
    end

    task automatic run_sweep(input sweep_vec_t v);
        int  n;
        bit  live;
        n = SZ * DW;
        @(negedge clk);
        word8  = v.word_a;
        start8 = 1'b1;
        if (v.exp_done) q8.push_back(v.exp_data);
        @(negedge clk);
        start8 = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            live = (v.abort_cycle == 0 || c <= v.abort_cycle) && (c <= n);
            if (c == v.switch_cycle) word8 = v.word_b;
            check("busy8", {31'd0, busy8}, {31'd0, live});
            check("sel8", {29'd0, sel8}, live ? (c - 1) / DW : 0);
            check("done8", {31'd0, done8}, {31'd0, (v.exp_done && c == n + 1)});
            abort8 = (c == v.abort_cycle);
            start8 = (c == v.restart_cycle);
            @(negedge clk);
        end
        abort8 = 1'b0;
        start8 = 1'b0;
        if (v.exp_done) last8 = v.exp_data;
        check("data8_after", {24'd0, data8}, {24'd0, last8});
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 0,  0,  0,  8'hA5, 1'b1};
        vecs[1] = '{8'hA5, 8'h3C, 17, 0,  0,  8'h35, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 0,  10, 0,  8'h00, 1'b0};
        vecs[3] = '{8'h5A, 8'h5A, 0,  0,  5,  8'h5A, 1'b1};
        vecs[4] = '{8'hC3, 8'hC3, 0,  0,  33, 8'hC3, 1'b1};
        vecs[5] = '{8'h81, 8'h7E, 1,  0,  0,  8'h7E, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 0,  32, 0,  8'h00, 1'b0};

        rst_n  = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; word8 = 8'h00;
        start5 = 1'b0; abort5 = 1'b0; word5 = 5'h00;
        last8  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_sel8",  {29'd0, sel8},  0);
        check("rst_busy8", {31'd0, busy8}, 0);
        check("rst_done8", {31'd0, done8}, 0);
        check("rst_data8", {24'd0, data8}, 0);
        check("rst_data5", {27'd0, data5}, 0);
        rst_n = 1'b1;

        // Start and abort together in IDLE: nothing happens.
        @(negedge clk);
        start8 = 1'b1; abort8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("sa_busy8", {31'd0, busy8}, 0);
            check("sa_sel8",  {29'd0, sel8},  0);
            @(negedge clk);
        end

        for (int i = 0; i < 7; i++) begin
            run_sweep(vecs[i]);
        end

        // SIZE=5, DWELL=1: select steps every cycle and never leaves 0..4.
        @(negedge clk);
        word5  = 5'b10110;
        start5 = 1'b1;
        q5.push_back(5'b10110);
        @(negedge clk);
        start5 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            check("sel5", {29'd0, sel5}, (c <= 5) ? c - 1 : 0);
            check("sel5_range", {31'd0, (sel5 <= 3'd4)}, 1);
            check("busy5", {31'd0, busy5}, {31'd0, (c <= 5)});
            check("done5", {31'd0, done5}, {31'd0, (c == 6)});
            @(negedge clk);
        end
        check("data5_final", {27'd0, data5}, {27'd0, 5'b10110});

        // Reset in cycle 12 of a sweep clears outputs without a clock edge.
        @(negedge clk);
        word8  = 8'hA5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_rst_busy8", {31'd0, busy8}, 1);
        rst_n = 1'b0;
        #1;
        check("arst_sel8",  {29'd0, sel8},  0);
        check("arst_busy8", {31'd0, busy8}, 0);
        check("arst_done8", {31'd0, done8}, 0);
        check("arst_data8", {24'd0, data8}, 0);
        check("arst_data5", {27'd0, data5}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last8 = 8'h00;

        run_sweep(vecs[0]);
        run_sweep(vecs[1]);

        repeat (2) @(negedge clk);
        check("sb8_drained", q8.size(), 0);
        check("sb5_drained", q5.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SIZE, default 8, is the number of mux channels swept (>=2, need not be a power of two).
REQ-002 Parameter DWELL, default 4, is the clock cycles spent on each channel (>=1).
REQ-003 clk  input  1  rising-edge system clock; the block has one clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 mux_scan_start  input  1  request one full sweep; sampled only in IDLE.
REQ-006 mux_scan_abort  input  1  terminate an active sweep.
REQ-007 mux_scan_sel  output  $clog2(SIZE)  select driven to the downstream N:1 mux.
REQ-008 mux_scan_in  input  1  single-bit output returned from that mux.
REQ-009 mux_scan_data  output  SIZE  captured word; bit k holds the value sampled on channel k.
REQ-010 mux_scan_busy  output  1  high while in SCAN.
REQ-011 mux_scan_done  output  1  one-cycle pulse marking new mux_scan_data.

Function
REQ-012 FSM states SHALL be IDLE, SCAN and DONE; the state is registered.
REQ-013 IDLE->SCAN on the edge where mux_scan_start=1 and mux_scan_abort=0; on that edge the channel index becomes 0, the dwell count becomes 0 and the shadow capture register clears to 0.
REQ-014 In SCAN, mux_scan_sel SHALL equal the current channel index k and hold stable for exactly DWELL cycles.
REQ-015 On the edge ending the DWELL-th cycle of channel k, mux_scan_in SHALL be written to shadow bit k.
REQ-016 On that same edge, if k<SIZE-1, k increments and the dwell count resets to 0.
REQ-017 If k=SIZE-1, the FSM goes to DONE and mux_scan_data loads the full shadow word, including the bit just sampled.
REQ-018 mux_scan_sel SHALL never exceed SIZE-1, including for non-power-of-two SIZE.
REQ-019 DONE lasts exactly one cycle with mux_scan_done=1, then returns to IDLE unconditionally.
REQ-020 Latency: with the start edge as E0, SCAN occupies cycles 1..SIZE*DWELL, mux_scan_done is high in cycle SIZE*DWELL+1, and the block is back in IDLE at E(SIZE*DWELL+2).
REQ-021 mux_scan_start SHALL be ignored in SCAN and DONE; it is not queued.
REQ-022 mux_scan_abort=1 in SCAN returns the FSM to IDLE on the next edge; mux_scan_data is unchanged and no done pulse is generated.
REQ-023 If abort coincides with the final sample edge, abort wins: no data load and no done.
REQ-024 mux_scan_abort in IDLE or DONE has no effect, except that in IDLE it blocks a simultaneous start.
REQ-025 For DWELL=1, the channel advances every cycle.
REQ-026 In IDLE and DONE, mux_scan_sel SHALL be 0.
REQ-027 mux_scan_busy SHALL be 1 exactly when the state is SCAN.
REQ-028 mux_scan_data SHALL change only on the DONE-entry edge or on reset.

Reset
REQ-029 rst_n low SHALL force, asynchronously, state=IDLE, mux_scan_sel=0, mux_scan_data=0, shadow=0, dwell count=0, mux_scan_busy=0 and mux_scan_done=0.
REQ-030 Reset asserted mid-sweep discards all partial samples.
REQ-031 After rst_n deasserts, the first start is honoured on the next qualifying edge.

Structure
REQ-032 Package mux_scan_pkg SHALL hold the state encoding (IDLE, SCAN, DONE) and the default SIZE and DWELL constants.
REQ-033 One sub-module, mux_scan_dwell_cnt, SHALL implement the dwell counter, with inputs clear and enable and output last (high when count=DWELL-1).
REQ-034 The mux itself stays external and is not instantiated in this block.

Verification
REQ-035 Bench loops mux_scan_sel to an 8:1 mux_nx1 with input 8'hA5 and SIZE=8, DWELL=4; pulse start -> busy high for 32 cycles, done high for 1 cycle in cycle 33, data=8'hA5.
REQ-036 Change the mux input to 8'h3C mid-sweep, after channel 3 has been sampled -> data holds old bits [3:0] and new bits [7:4] per the sample edges; done is still a single pulse.
REQ-037 Assert abort in cycle 10 of a sweep -> busy drops on the next edge, no done pulse, data keeps its previous value; a following start completes normally.
REQ-038 Set SIZE=5, DWELL=1 with input 5'b10110 -> mux_scan_sel steps 0,1,2,3,4 (never 5-7), done in cycle 6, data=5'b10110.
REQ-039 Pulse rst_n low in cycle 12 of a sweep -> sel, busy, done and data read 0 immediately without waiting for a clock edge; start after release sweeps cleanly.
REQ-040 Assert start and abort together in IDLE -> the block stays in IDLE; start asserted during SCAN -> no second sweep and exactly one done pulse.
